scv_init_loader: RTL and testbench
==================================

# scv_init_loader

Host-download adapter sitting directly upstream of the uPD7801 wrapper's `INIT_*` port.
- Converts the frontend's 16-bit download stream into the byte-wide `INIT_SEL_BOOT`/`INIT_ADDR`/`INIT_DATA`/`INIT_VALID` writes that fill the 4 KiB internal boot ROM.
- Produces a parallel cartridge write stream.
- Holds the CPU in reset while a download is in progress, and for a fixed interval afterwards.

## Interface
Parameters:
- `BOOT_INDEX`, 8'd0, download index selecting the internal boot ROM
- `CART_INDEX`, 8'd1, download index selecting cartridge memory
- `RST_HOLD`, 16, CLK cycles `CPU_RESETB` stays low after the download ends or after reset; range 1..255

Ports:
- `CLK`  in  1  system clock
- `RESETB`  in  1  reset; one clock, asynchronous, active-low
- `DL_ACTIVE`  in  1  download in progress
- `DL_INDEX`  in  8  download target index, stable while `DL_ACTIVE`
- `DL_ADDR`  in  25  byte address of the word; bit 0 ignored
- `DL_DATA`  in  16  data word; `[7:0]` goes to the even byte
- `DL_WR`  in  1  one-cycle word strobe
- `DL_WAIT`  out  1  loader busy; `DL_WR` is not accepted while high
- `INIT_SEL_BOOT`  out  1  current write targets the boot ROM
- `INIT_SEL_CART`  out  1  current write targets the cartridge
- `INIT_ADDR`  out  25  byte write address
- `INIT_DATA`  out  8  byte write data
- `INIT_VALID`  out  1  byte write strobe, one cycle per byte
- `CPU_RESETB`  out  1  reset to the uPD7801 (active-low)
- `BOOT_SUM`  out  8  modulo-256 sum of boot bytes written

## Operation
FSM states:
- IDLE: `DL_WAIT`=0. `DL_WR`=1 latches `DL_ADDR` with bit 0 forced to 0, `DL_DATA`, and `DL_INDEX`, then goes to LO.
- LO: emits the low byte at the latched address; goes to HI.
- HI: emits the high byte at address+1; returns to IDLE.

Byte emission rules:
- `DL_WAIT`=1 in LO and HI. A `DL_WR` arriving in LO or HI is dropped and not queued.
- `INIT_SEL_BOOT` = latched index == `BOOT_INDEX`; `INIT_SEL_CART` = latched index == `CART_INDEX`. Both are held from the accept until the next accept.
- Boot byte with address >= 'h1000: `INIT_VALID` is suppressed for that byte. `INIT_ADDR`/`INIT_DATA` still update.
- Index matching neither parameter: both selects are 0 and `INIT_VALID` is suppressed.
- `INIT_ADDR`+1 is 25-bit modulo; 'h1FFFFFE wraps to 'h1FFFFFF (no carry out).

CPU reset control:
- An 8-bit hold counter is loaded with `RST_HOLD` while `RESETB`=0, while `DL_ACTIVE`=1, and while the FSM is not in IDLE.
- Otherwise it decrements to 0.
- `CPU_RESETB` = (counter == 0) & ~`DL_ACTIVE`.
- `DL_ACTIVE` falling mid-word: the pending word completes (both bytes), then the hold count starts.

Reset and concurrency:
- `RESETB` low mid-word aborts the word immediately: no further `INIT_VALID`, FSM returns to IDLE.
- Reset values: FSM IDLE, `DL_WAIT` 0, `INIT_*` all 0, `CPU_RESETB` 0, counter = `RST_HOLD`, `BOOT_SUM` 0.
- `DL_ACTIVE` rising clears `BOOT_SUM` to 0 when the checksum is enabled. If it coincides with a boot byte, the clear wins.

## Timing
- Accept in cycle N. Low byte `INIT_VALID`=1 in N+1; high byte in N+2.
- `DL_WAIT` is high in N+1 and N+2. The next `DL_WR` is accepted no earlier than N+3.
- Sustained throughput: one word per 3 cycles.
- All outputs are registered; there are no combinational paths from inputs.
- After `RESETB` rises with `DL_ACTIVE`=0, `CPU_RESETB` rises on exactly the `RST_HOLD`-th rising `CLK` edge.
- After `DL_ACTIVE` falls in cycle M with the FSM idle, `CPU_RESETB`=1 from cycle M+`RST_HOLD`.

## Configuration
- `SCV_INIT_CHECKSUM_EN` defined: `BOOT_SUM` adds `INIT_DATA` on every cycle where `INIT_VALID`=1 and `INIT_SEL_BOOT`=1. Addition is modulo 256. The sum holds its value after the download ends.
- `SCV_INIT_CHECKSUM_EN` undefined: `BOOT_SUM` is constant 0, no adder is built, all other behaviour is identical.

## Test plan
- Reset release, `RST_HOLD`=16, `DL_ACTIVE`=0 -> `CPU_RESETB`=0 for 16 edges, then 1; all `INIT_*` 0 throughout.
- `DL_INDEX`=0, `DL_WR` with `DL_ADDR`='h0FFE, `DL_DATA`='hA55A -> cycle N+1: `INIT_ADDR`='h0FFE, `INIT_DATA`='h5A, `INIT_VALID`=1, `INIT_SEL_BOOT`=1; N+2: 'h0FFF/'hA5, `INIT_VALID`=1.
- Boot write to `DL_ADDR`='h1000 -> `INIT_VALID` stays 0 for both bytes. Same address with `DL_INDEX`=1 -> two strobes with `INIT_SEL_CART`=1.
- `DL_WR` in N and again in N+1 -> second word dropped, exactly 2 `INIT_VALID` pulses. `DL_WR` in N+3 -> accepted.
- `DL_ACTIVE` falls in the cycle of an accept -> both bytes still written; `CPU_RESETB` rises `RST_HOLD` cycles after the high byte. `RESETB` asserted in LO -> no high byte, `CPU_RESETB`=0 immediately.
- With `SCV_INIT_CHECKSUM_EN`: boot words 'h0201, 'h00FF -> `BOOT_SUM`='h02. Without the macro -> `BOOT_SUM`=0.

Source files
------------

// File: rtl/scv_init_loader_if.sv
// Download/boot-init bus for scv_init_loader.
// slave: the loader (consumes the 16-bit download stream, drives the byte-wide INIT_* writes).
// master: the host/frontend side.
interface scv_init_loader_if;
  logic        DL_ACTIVE;
  logic [7:0]  DL_INDEX;
  logic [24:0] DL_ADDR;
  logic [15:0] DL_DATA;
  logic        DL_WR;
  logic        DL_WAIT;
  logic        INIT_SEL_BOOT;
  logic        INIT_SEL_CART;
  logic [24:0] INIT_ADDR;
  logic [7:0]  INIT_DATA;
  logic        INIT_VALID;

  modport slave (
    input  DL_ACTIVE, DL_INDEX, DL_ADDR, DL_DATA, DL_WR,
    output DL_WAIT, INIT_SEL_BOOT, INIT_SEL_CART, INIT_ADDR, INIT_DATA, INIT_VALID
  );

  modport master (
    output DL_ACTIVE, DL_INDEX, DL_ADDR, DL_DATA, DL_WR,
    input  DL_WAIT, INIT_SEL_BOOT, INIT_SEL_CART, INIT_ADDR, INIT_DATA, INIT_VALID
  );
endinterface

// File: rtl/scv_init_loader.sv
// scv_init_loader: splits 16-bit download words into two byte writes for the
// uPD7801 boot ROM / cartridge and holds the CPU in reset during and after a
// download. Optional boot-byte checksum on BOOT_SUM: define SCV_INIT_CHECKSUM_EN.
module scv_init_loader #(
  parameter logic [7:0]  BOOT_INDEX = 8'd0,
  parameter logic [7:0]  CART_INDEX = 8'd1,
  parameter int unsigned RST_HOLD   = 16
) (
  input  logic             CLK,
  input  logic             RESETB,
  scv_init_loader_if.slave dl,
  output logic             CPU_RESETB,
  output logic [7:0]       BOOT_SUM
);

  localparam logic [7:0]  HOLD_INIT  = 8'(RST_HOLD);
  localparam logic [24:0] BOOT_LIMIT = 25'h1000;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

  state_t      state_q, state_d;
  logic        sel_boot_q, sel_boot_d;
  logic        sel_cart_q, sel_cart_d;
  logic        valid_q, valid_d;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  hi_q, hi_d;
  logic [7:0]  hold_q, hold_d;
  logic        cpu_rstb_q, cpu_rstb_d;

  logic [24:0] even_addr;
  logic [24:0] next_addr;
  logic        new_boot;
  logic        new_cart;

  // Boot bytes beyond the 4 KiB ROM and unknown targets are not strobed.
  function automatic logic byte_ok(input logic boot, input logic cart, input logic [24:0] a);
    return cart | (boot & (a < BOOT_LIMIT));
  endfunction

  assign even_addr = dl.DL_ADDR & ~25'd1;
  assign next_addr = addr_q + 25'd1;
  assign new_boot  = (dl.DL_INDEX == BOOT_INDEX);
  assign new_cart  = (dl.DL_INDEX == CART_INDEX);

  // Word FSM: accept in IDLE, emit low byte on the accept edge, high byte from LO.
  always_comb begin
    state_d    = state_q;
    sel_boot_d = sel_boot_q;
    sel_cart_d = sel_cart_q;
    addr_d     = addr_q;
    data_d     = data_q;
    hi_d       = hi_q;
    valid_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dl.DL_WR) begin
          sel_boot_d = new_boot;
          sel_cart_d = new_cart;
          addr_d     = even_addr;
          data_d     = dl.DL_DATA[7:0];
          hi_d       = dl.DL_DATA[15:8];
          valid_d    = byte_ok(new_boot, new_cart, even_addr);
          state_d    = S_LO;
        end
      end
      S_LO: begin
        addr_d  = next_addr;
        data_d  = hi_q;
        valid_d = byte_ok(sel_boot_q, sel_cart_q, next_addr);
        state_d = S_HI;
      end
      S_HI:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // CPU reset hold: reload while downloading or mid-word, otherwise count down.
  always_comb begin
    if (dl.DL_ACTIVE || (state_q != S_IDLE)) begin
      hold_d = HOLD_INIT;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 8'd1;
    end else begin
      hold_d = hold_q;
    end
    cpu_rstb_d = (hold_d == '0) & ~dl.DL_ACTIVE;
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q    <= S_IDLE;
      sel_boot_q <= 1'b0;
      sel_cart_q <= 1'b0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      hi_q       <= '0;
      hold_q     <= HOLD_INIT;
      cpu_rstb_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_boot_q <= sel_boot_d;
      sel_cart_q <= sel_cart_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hi_q       <= hi_d;
      hold_q     <= hold_d;
      cpu_rstb_q <= cpu_rstb_d;
    end
  end

  assign dl.DL_WAIT       = (state_q != S_IDLE);
  assign dl.INIT_SEL_BOOT = sel_boot_q;
  assign dl.INIT_SEL_CART = sel_cart_q;
  assign dl.INIT_ADDR     = addr_q;
  assign dl.INIT_DATA     = data_q;
  assign dl.INIT_VALID    = valid_q;
  assign CPU_RESETB       = cpu_rstb_q;

`ifdef SCV_INIT_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       act_q;

  // Running boot-byte sum; a new download (DL_ACTIVE rising) restarts it.
  always_comb begin
    sum_d = sum_q;
    if (dl.DL_ACTIVE && !act_q) begin
      sum_d = '0;
    end else if (valid_q && sel_boot_q) begin
      sum_d = sum_q + data_q;
    end
  end

  // Checksum registers.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      sum_q <= '0;
      act_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      act_q <= dl.DL_ACTIVE;
    end
  end

  assign BOOT_SUM = sum_q;
`else
  assign BOOT_SUM = '0;
`endif

endmodule

// File: tb/tb_scv_init_loader.sv
// Self-checking bench for scv_init_loader: directed scenarios plus randomized
// traffic checked against a queue-based byte-event model.
module tb_scv_init_loader;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       cpu_rstb;
  logic [7:0] boot_sum;

  always #5 clk = ~clk;

  scv_init_loader_if bus ();

  scv_init_loader #(
    .BOOT_INDEX(8'd0),
    .CART_INDEX(8'd1),
    .RST_HOLD  (H)
  ) dut (
    .CLK       (clk),
    .RESETB    (rstb),
    .dl        (bus),
    .CPU_RESETB(cpu_rstb),
    .BOOT_SUM  (boot_sum)
  );

  typedef struct packed {
    logic        v;
    logic        b;
    logic        c;
    logic [24:0] a;
    logic [7:0]  d;
  } ev_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_cyc = 0;
  int          m_blast = 0;
  logic        m_busy = 1'b0, m_valid = 1'b0, m_boot = 1'b0, m_cart = 1'b0;
  logic        m_prev_act = 1'b0, m_exp_cpu = 1'b0;
  logic [24:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [7:0]  m_sum = '0;
  ev_t         m_q[$];

`ifdef SCV_INIT_CHECKSUM_EN
  localparam logic [7:0] EXP_SUM = 8'h02;
`else
  localparam logic [7:0] EXP_SUM = 8'h00;
`endif

  // Drive one cycle of inputs (called at negedge), advance the model, return at next negedge.
  task automatic cyc(input logic wr, input logic act, input logic [7:0] idx,
                     input logic [24:0] addr, input logic [15:0] data);
    ev_t e0, e1;
    bus.DL_WR = wr; bus.DL_ACTIVE = act; bus.DL_INDEX = idx;
    bus.DL_ADDR = addr; bus.DL_DATA = data;
    if (wr && !m_busy) begin
      e0.b = (idx == 8'd0);
      e0.c = (idx == 8'd1);
      e0.a = {addr[24:1], 1'b0};
      e0.d = data[7:0];
      e0.v = e0.c || (e0.b && (e0.a < 25'h1000));
      e1   = e0;
      e1.a = e0.a + 25'd1;
      e1.d = data[15:8];
      e1.v = e1.c || (e1.b && (e1.a < 25'h1000));
      m_q.push_back(e0);
      m_q.push_back(e1);
    end
`ifdef SCV_INIT_CHECKSUM_EN
    if (act && !m_prev_act) m_sum = 8'h00;
    else if (m_valid && m_boot) m_sum = m_sum + m_data;
`endif
    m_prev_act = act;
    if (act || m_busy) m_blast = m_cyc;
    @(posedge clk);
    m_cyc++;
    if (m_q.size() > 0) begin
      e0 = m_q.pop_front();
      m_valid = e0.v; m_addr = e0.a; m_data = e0.d; m_boot = e0.b; m_cart = e0.c;
      m_busy = 1'b1;
    end else begin
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end
    m_exp_cpu = (m_cyc >= m_blast + 1 + H);
    @(negedge clk);
  endtask

  task automatic hit_reset();
    rstb = 1'b0;
    bus.DL_WR = 1'b0;
    m_q.delete();
    m_valid = 0; m_busy = 0; m_boot = 0; m_cart = 0;
    m_addr = '0; m_data = '0; m_sum = '0; m_prev_act = 0; m_exp_cpu = 0;
  endtask

  task automatic release_reset(input int n);
    repeat (n) begin
      @(posedge clk);
      m_cyc++;
    end
    @(negedge clk);
    rstb = 1'b1;
    m_blast = m_cyc - 1;
  endtask

  task automatic test_reset();
    bus.DL_ACTIVE = 0; bus.DL_INDEX = 0; bus.DL_ADDR = '0; bus.DL_DATA = '0;
    hit_reset();
    @(negedge clk);
    n_vec++;
    if ({cpu_rstb, bus.INIT_VALID, bus.INIT_SEL_BOOT, bus.INIT_SEL_CART, bus.INIT_ADDR,
         bus.INIT_DATA, bus.DL_WAIT, boot_sum} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got cpu=%0b v=%0b sb=%0b sc=%0b a=%h d=%h w=%0b sum=%h exp all 0",
               cpu_rstb, bus.INIT_VALID, bus.INIT_SEL_BOOT, bus.INIT_SEL_CART,
               bus.INIT_ADDR, bus.INIT_DATA, bus.DL_WAIT, boot_sum);
    end
    release_reset(2);
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 8'd0, '0, '0);
      n_vec++;
      if (cpu_rstb !== (k >= H)) begin
        n_err++;
        $display("FAIL reset_release_cpu k=%0d got=%0b exp=%0b", k, cpu_rstb, (k >= H));
      end
      n_vec++;
      if ({bus.INIT_VALID, bus.INIT_SEL_BOOT, bus.INIT_SEL_CART, bus.INIT_ADDR, bus.INIT_DATA} !== '0) begin
        n_err++;
        $display("FAIL reset_release_init k=%0d got v=%0b a=%h d=%h exp 0", k,
                 bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA);
      end
    end
  endtask

  task automatic test_boot_word();
    cyc(0, 1, 8'd0, '0, '0);
    cyc(1, 1, 8'd0, 25'h0FFE, 16'hA55A);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_SEL_BOOT, bus.INIT_SEL_CART, bus.INIT_ADDR, bus.INIT_DATA, bus.DL_WAIT}
        !== {1'b1, 1'b1, 1'b0, 25'h0FFE, 8'h5A, 1'b1}) begin
      n_err++;
      $display("FAIL boot_lo got v=%0b sb=%0b sc=%0b a=%h d=%h w=%0b exp v=1 sb=1 sc=0 a=0ffe d=5a w=1",
               bus.INIT_VALID, bus.INIT_SEL_BOOT, bus.INIT_SEL_CART, bus.INIT_ADDR, bus.INIT_DATA, bus.DL_WAIT);
    end
    cyc(0, 1, 8'd0, '0, '0);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA, bus.DL_WAIT} !== {1'b1, 25'h0FFF, 8'hA5, 1'b1}) begin
      n_err++;
      $display("FAIL boot_hi got v=%0b a=%h d=%h w=%0b exp v=1 a=0fff d=a5 w=1",
               bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA, bus.DL_WAIT);
    end
    cyc(0, 1, 8'd0, '0, '0);
    n_vec++;
    if ({bus.INIT_VALID, bus.DL_WAIT, bus.INIT_SEL_BOOT} !== 3'b001) begin
      n_err++;
      $display("FAIL boot_after got v=%0b w=%0b sb=%0b exp v=0 w=0 sb=1",
               bus.INIT_VALID, bus.DL_WAIT, bus.INIT_SEL_BOOT);
    end
  endtask

  task automatic test_boot_oob();
    cyc(1, 1, 8'd0, 25'h1000, 16'h1234);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA} !== {1'b0, 25'h1000, 8'h34}) begin
      n_err++;
      $display("FAIL oob_lo got v=%0b a=%h d=%h exp v=0 a=1000 d=34", bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA);
    end
    cyc(0, 1, 8'd0, '0, '0);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA} !== {1'b0, 25'h1001, 8'h12}) begin
      n_err++;
      $display("FAIL oob_hi got v=%0b a=%h d=%h exp v=0 a=1001 d=12", bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA);
    end
    cyc(0, 1, 8'd1, '0, '0);
    cyc(1, 1, 8'd1, 25'h1000, 16'h5678);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_SEL_CART, bus.INIT_SEL_BOOT, bus.INIT_DATA} !== {3'b110, 8'h78}) begin
      n_err++;
      $display("FAIL cart_lo got v=%0b sc=%0b sb=%0b d=%h exp v=1 sc=1 sb=0 d=78",
               bus.INIT_VALID, bus.INIT_SEL_CART, bus.INIT_SEL_BOOT, bus.INIT_DATA);
    end
    cyc(0, 1, 8'd1, '0, '0);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_SEL_CART, bus.INIT_ADDR, bus.INIT_DATA} !== {2'b11, 25'h1001, 8'h56}) begin
      n_err++;
      $display("FAIL cart_hi got v=%0b sc=%0b a=%h d=%h exp v=1 sc=1 a=1001 d=56",
               bus.INIT_VALID, bus.INIT_SEL_CART, bus.INIT_ADDR, bus.INIT_DATA);
    end
    cyc(0, 1, 8'd1, '0, '0);
  endtask

  task automatic test_back_to_back();
    cyc(1, 1, 8'd1, 25'h0200, 16'h2211);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_DATA} !== {1'b1, 8'h11}) begin
      n_err++;
      $display("FAIL b2b_first_lo got v=%0b d=%h exp v=1 d=11", bus.INIT_VALID, bus.INIT_DATA);
    end
    cyc(1, 1, 8'd1, 25'h0300, 16'h4433);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA} !== {1'b1, 25'h0201, 8'h22}) begin
      n_err++;
      $display("FAIL b2b_first_hi got v=%0b a=%h d=%h exp v=1 a=0201 d=22", bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA);
    end
    cyc(1, 1, 8'd1, 25'h0400, 16'h6655);
    n_vec++;
    if ({bus.INIT_VALID, bus.DL_WAIT} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_dropped got v=%0b w=%0b exp v=0 w=0", bus.INIT_VALID, bus.DL_WAIT);
    end
    cyc(1, 1, 8'd1, 25'h0501, 16'h8877);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA} !== {1'b1, 25'h0500, 8'h77}) begin
      n_err++;
      $display("FAIL b2b_n3_lo got v=%0b a=%h d=%h exp v=1 a=0500 d=77", bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA);
    end
    cyc(0, 1, 8'd1, '0, '0);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA} !== {1'b1, 25'h0501, 8'h88}) begin
      n_err++;
      $display("FAIL b2b_n3_hi got v=%0b a=%h d=%h exp v=1 a=0501 d=88", bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA);
    end
    cyc(0, 1, 8'd1, '0, '0);
  endtask

  task automatic test_active_fall();
    cyc(0, 1, 8'd0, '0, '0);
    cyc(1, 0, 8'd0, 25'h0010, 16'hBEEF);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_DATA, cpu_rstb} !== {1'b1, 8'hEF, 1'b0}) begin
      n_err++;
      $display("FAIL fall_lo got v=%0b d=%h cpu=%0b exp v=1 d=ef cpu=0", bus.INIT_VALID, bus.INIT_DATA, cpu_rstb);
    end
    cyc(0, 0, 8'd0, '0, '0);
    n_vec++;
    if ({bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA} !== {1'b1, 25'h0011, 8'hBE}) begin
      n_err++;
      $display("FAIL fall_hi got v=%0b a=%h d=%h exp v=1 a=0011 d=be", bus.INIT_VALID, bus.INIT_ADDR, bus.INIT_DATA);
    end
    for (int k = 3; k <= 22; k++) begin
      cyc(0, 0, 8'd0, '0, '0);
      n_vec++;
      if (cpu_rstb !== (k >= H + 3)) begin
        n_err++;
        $display("FAIL fall_cpu k=%0d got=%0b exp=%0b", k, cpu_rstb, (k >= H + 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 8'd1, '0, '0);
    cyc(1, 1, 8'd1, 25'h0100, 16'hC3C3);
    n_vec++;
    if (bus.INIT_VALID !== 1'b1) begin
      n_err++;
      $display("FAIL mid_lo got v=%0b exp v=1", bus.INIT_VALID);
    end
    hit_reset();
    #1;
    n_vec++;
    if ({bus.INIT_VALID, cpu_rstb, bus.DL_WAIT, bus.INIT_ADDR} !== '0) begin
      n_err++;
      $display("FAIL mid_reset got v=%0b cpu=%0b w=%0b a=%h exp 0", bus.INIT_VALID, cpu_rstb, bus.DL_WAIT, bus.INIT_ADDR);
    end
    release_reset(1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 8'd1, '0, '0);
      n_vec++;
      if (bus.INIT_VALID !== 1'b0) begin
        n_err++;
        $display("FAIL mid_no_hi k=%0d got v=%0b exp v=0", k, bus.INIT_VALID);
      end
    end
  endtask

  task automatic test_checksum();
    cyc(0, 0, 8'd0, '0, '0);
    cyc(0, 1, 8'd0, '0, '0);
    cyc(1, 1, 8'd0, 25'h0000, 16'h0201);
    cyc(0, 1, 8'd0, '0, '0);
    cyc(0, 1, 8'd0, '0, '0);
    cyc(1, 1, 8'd0, 25'h0002, 16'h00FF);
    repeat (3) cyc(0, 1, 8'd0, '0, '0);
    n_vec++;
    if (boot_sum !== EXP_SUM) begin
      n_err++;
      $display("FAIL checksum got=%h exp=%h", boot_sum, EXP_SUM);
    end
    repeat (2) cyc(0, 0, 8'd0, '0, '0);
    n_vec++;
    if (boot_sum !== EXP_SUM) begin
      n_err++;
      $display("FAIL checksum_hold got=%h exp=%h", boot_sum, EXP_SUM);
    end
  endtask

  task automatic test_random();
    logic        act = 1'b1;
    logic        wr;
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [7:0]  idx_tab [5];
    idx_tab[0] = 8'd0; idx_tab[1] = 8'd1; idx_tab[2] = 8'd2; idx_tab[3] = 8'd0; idx_tab[4] = 8'h55;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        hit_reset();
        release_reset(2);
      end
      if ($urandom_range(0, 19) == 0) act = ~act;
      wr  = act ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      idx = idx_tab[$urandom_range(0, 4)];
      case ($urandom_range(0, 3))
        0:       addr = 25'h0FF0 + 25'($urandom_range(0, 31));
        1:       addr = 25'h1FFFFFE + 25'($urandom_range(0, 1));
        2:       addr = 25'($urandom_range(0, 4095));
        default: addr = 25'($urandom);
      endcase
      cyc(wr, act, idx, addr, 16'($urandom));
      n_vec++;
      if (bus.INIT_VALID !== m_valid) begin
        n_err++;
        $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", m_cyc, bus.INIT_VALID, m_valid);
      end
      n_vec++;
      if (bus.INIT_ADDR !== m_addr) begin
        n_err++;
        $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", m_cyc, bus.INIT_ADDR, m_addr);
      end
      n_vec++;
      if (bus.INIT_DATA !== m_data) begin
        n_err++;
        $display("FAIL rnd_data cyc=%0d got=%h exp=%h", m_cyc, bus.INIT_DATA, m_data);
      end
      n_vec++;
      if ({bus.INIT_SEL_BOOT, bus.INIT_SEL_CART} !== {m_boot, m_cart}) begin
        n_err++;
        $display("FAIL rnd_sel cyc=%0d got=%b%b exp=%b%b", m_cyc, bus.INIT_SEL_BOOT, bus.INIT_SEL_CART, m_boot, m_cart);
      end
      n_vec++;
      if (bus.DL_WAIT !== m_busy) begin
        n_err++;
        $display("FAIL rnd_wait cyc=%0d got=%0b exp=%0b", m_cyc, bus.DL_WAIT, m_busy);
      end
      n_vec++;
      if (cpu_rstb !== m_exp_cpu) begin
        n_err++;
        $display("FAIL rnd_cpu cyc=%0d got=%0b exp=%0b", m_cyc, cpu_rstb, m_exp_cpu);
      end
      n_vec++;
      if (boot_sum !== m_sum) begin
        n_err++;
        $display("FAIL rnd_sum cyc=%0d got=%h exp=%h", m_cyc, boot_sum, m_sum);
      end
    end
  endtask

  initial begin
    bus.DL_WR = 1'b0;
    test_reset();
    test_boot_word();
    test_boot_oob();
    test_back_to_back();
    test_active_fall();
    test_reset_mid();
    test_checksum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached at cycle %0d", m_cyc);
    $fatal(1, "watchdog");
  end
endmodule
